// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search engine.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sar_state_e;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } cmp_flags_t;

    // A comparator answer is meaningful only when exactly one flag is set
    function automatic logic cmp_legal(cmp_flags_t f);
        return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
    endfunction

endpackage

// File: rtl/sar_step_unit.sv
// One SAR decision: keeps or drops the bit under test and flags illegal comparator answers.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module sar_step_unit
    import sar_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [IDX_W-1:0] idx,
    input  cmp_flags_t       flags,
    output logic [WIDTH-1:0] next_acc,
    output logic             last_bit,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] trial;

    // Candidate with the bit under test set; it survives unless probe > target
    always_comb begin
        trial    = acc | (ONE << idx);
        next_acc = flags.gt ? acc : trial;
        last_bit = (idx == '0);
        illegal  = !cmp_legal(flags);
    end

endmodule

// File: rtl/sar_search_unsigned.sv
// SAR search: recovers an unsigned target one bit per probe, MSB first (SAR_EARLY_EXIT_EN stops on eq).
// Latency: 2*WIDTH+1 cycles from start accept to done_o with a zero-wait comparator, +1 per wait cycle.
// Backpressure: probe held with probe_valid_o until cmp_valid_i; start_i ignored unless ready_o.
module sar_search_unsigned
    import sar_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] probe_o,
    output logic             probe_valid_o,
    input  logic             cmp_valid_i,
    input  logic             cmp_eq_i,
    input  logic             cmp_lt_i,
    input  logic             cmp_gt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o,
    output logic             error_o
);

    localparam int               IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    sar_state_e       state;
    logic [WIDTH-1:0] acc;
    logic [IDX_W-1:0] idx;

    cmp_flags_t       flags;
    logic [WIDTH-1:0] next_acc;
    logic             last_bit;
    logic             illegal;
    logic             early_hit;

    assign flags = {cmp_eq_i, cmp_lt_i, cmp_gt_i};

    sar_step_unit #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_step (
        .acc      (acc),
        .idx      (idx),
        .flags    (flags),
        .next_acc (next_acc),
        .last_bit (last_bit),
        .illegal  (illegal)
    );

`ifdef SAR_EARLY_EXIT_EN
    // An exact match means every remaining bit of acc is already correct
    assign early_hit = flags.eq;
`else
    // eq is handled like lt: the bit is kept and the scan runs to the LSB
    assign early_hit = 1'b0;
`endif

    // Search FSM with registered outputs; abort overrides any comparator answer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            acc           <= '0;
            idx           <= '0;
            ready_o       <= 1'b1;
            probe_o       <= '0;
            probe_valid_o <= 1'b0;
            result_o      <= '0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (abort_i && (state != IDLE)) begin
                state         <= IDLE;
                ready_o       <= 1'b1;
                probe_valid_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            acc     <= '0;
                            idx     <= IDX_MAX;
                            error_o <= 1'b0;
                            ready_o <= 1'b0;
                            state   <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        probe_o       <= acc | (ONE << idx);
                        probe_valid_o <= 1'b1;
                        state         <= WAIT;
                    end
                    WAIT: begin
                        if (cmp_valid_i) begin
                            probe_valid_o <= 1'b0;
                            if (illegal) begin
                                error_o <= 1'b1;
                                ready_o <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                acc <= next_acc;
                                if (last_bit || early_hit) begin
                                    state <= DONE;
                                end else begin
                                    idx   <= idx - 1'b1;
                                    state <= ISSUE;
                                end
                            end
                        end
                    end
                    DONE: begin
                        result_o <= acc;
                        done_o   <= 1'b1;
                        ready_o  <= 1'b1;
                        state    <= IDLE;
                    end
                    default: begin
                        ready_o       <= 1'b1;
                        probe_valid_o <= 1'b0;
                        state         <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_search_unsigned.sv
// Directed bench for sar_search_unsigned against a behavioural comparator on target T.
// Latency: checks done_o timing in cycles after the start-accept edge.
// Backpressure: responder inserts random wait cycles before answering.
module tb_sar_search_unsigned;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic        abort_i;
    logic        ready_o;
    logic [31:0] probe_o;
    logic        probe_valid_o;
    logic        cmp_valid_i;
    logic        cmp_eq_i;
    logic        cmp_lt_i;
    logic        cmp_gt_i;
    logic [31:0] result_o;
    logic        done_o;
    logic        error_o;

    int vectors  = 0;
    int failures = 0;

    sar_search_unsigned #(.WIDTH(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .ready_o       (ready_o),
        .probe_o       (probe_o),
        .probe_valid_o (probe_valid_o),
        .cmp_valid_i   (cmp_valid_i),
        .cmp_eq_i      (cmp_eq_i),
        .cmp_lt_i      (cmp_lt_i),
        .cmp_gt_i      (cmp_gt_i),
        .result_o      (result_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts a search and answers probes as a comparator against t.
    // err_probe: probe number answered with eq=lt=1 (0 = never).
    // abort_wait: WAIT cycle number on which abort_i is raised (0 = never).
    task automatic run(input logic [31:0] t, input int wmax, input int err_probe,
                       input int abort_wait, output bit got_done, output int cyc,
                       output int probes, output int gts, output bit stable_ok);
        bit          stopped;
        bit          in_wait;
        int          waitcnt;
        int          remain;
        logic [31:0] cur;
        got_done  = 1'b0;
        stopped   = 1'b0;
        in_wait   = 1'b0;
        stable_ok = 1'b1;
        cyc       = 0;
        probes    = 0;
        gts       = 0;
        waitcnt   = 0;
        remain    = 0;
        cur       = '0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int n = 0; n < 1000 && !got_done && !stopped; n++) begin
            cmp_valid_i = 1'b0;
            abort_i     = 1'b0;
            if (done_o) begin
                got_done = 1'b1;
            end else if (probe_valid_o) begin
                waitcnt++;
                if (!in_wait) begin
                    in_wait = 1'b1;
                    cur     = probe_o;
                    probes++;
                    remain  = $urandom_range(wmax, 0);
                end else if (probe_o !== cur) begin
                    stable_ok = 1'b0;
                end
                if (abort_wait != 0 && waitcnt == abort_wait) begin
                    abort_i     = 1'b1;
                    cmp_valid_i = 1'b1;
                    cmp_eq_i    = (cur == t);
                    cmp_lt_i    = (cur < t);
                    cmp_gt_i    = (cur > t);
                    stopped     = 1'b1;
                end else if (remain == 0) begin
                    cmp_valid_i = 1'b1;
                    cmp_eq_i    = (cur == t);
                    cmp_lt_i    = (cur < t);
                    cmp_gt_i    = (cur > t);
                    if (cur > t) gts++;
                    if (probes == err_probe) begin
                        cmp_eq_i = 1'b1;
                        cmp_lt_i = 1'b1;
                        cmp_gt_i = 1'b0;
                        stopped  = 1'b1;
                    end
                    in_wait = 1'b0;
                end else begin
                    remain--;
                    {cmp_eq_i, cmp_lt_i, cmp_gt_i} = 3'($urandom);
                end
            end
            if (!got_done) begin
                @(negedge clk_i);
                cyc++;
            end
        end
        cmp_valid_i = 1'b0;
        abort_i     = 1'b0;
    endtask

    // Watches a few cycles for a stray done_o
    task automatic quiet(input int ncyc, output bit saw_done);
        saw_done = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            if (done_o) saw_done = 1'b1;
            @(negedge clk_i);
        end
    endtask

    initial begin : stim
        bit got_done;
        bit stable_ok;
        bit saw_done;
        int cyc;
        int probes;
        int gts;

        start_i     = 1'b0;
        abort_i     = 1'b0;
        cmp_valid_i = 1'b0;
        cmp_eq_i    = 1'b0;
        cmp_lt_i    = 1'b0;
        cmp_gt_i    = 1'b0;
        rst_ni      = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_probe", probe_o, 32'd0);
        chk("rst_pvld",  32'(probe_valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_done",  32'(done_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);

        // MSB-only target
        run(32'h8000_0000, 0, 0, 0, got_done, cyc, probes, gts, stable_ok);
        chk("msb_done", 32'(got_done), 32'd1);
        chk("msb_result", result_o, 32'h8000_0000);
`ifdef SAR_EARLY_EXIT_EN
        chk("msb_latency", 32'(cyc), 32'd3);
`else
        chk("msb_latency", 32'(cyc), 32'd65);
        chk("msb_probes", 32'(probes), 32'd32);
`endif
        @(negedge clk_i);
        chk("done_pulse", 32'(done_o), 32'd0);

        // All ones: every probe is lt/eq
        run(32'hFFFF_FFFF, 0, 0, 0, got_done, cyc, probes, gts, stable_ok);
        chk("ones_result", result_o, 32'hFFFF_FFFF);
        chk("ones_latency", 32'(cyc), 32'd65);
        chk("ones_gts", 32'(gts), 32'd0);

        // Zero: every probe is gt
        run(32'h0000_0000, 0, 0, 0, got_done, cyc, probes, gts, stable_ok);
        chk("zero_result", result_o, 32'h0000_0000);
        chk("zero_gts", 32'(gts), 32'd32);
        chk("zero_latency", 32'(cyc), 32'd65);

        // Slow responder
        run(32'hDEAD_BEEF, 3, 0, 0, got_done, cyc, probes, gts, stable_ok);
        chk("slow_done", 32'(got_done), 32'd1);
        chk("slow_result", result_o, 32'hDEAD_BEEF);
        chk("slow_stable", 32'(stable_ok), 32'd1);

        // Illegal eq+lt on the 5th probe
        run(32'h1234_5678, 0, 5, 0, got_done, cyc, probes, gts, stable_ok);
        chk("err_flag", 32'(error_o), 32'd1);
        chk("err_ready", 32'(ready_o), 32'd1);
        chk("err_pvld", 32'(probe_valid_o), 32'd0);
        chk("err_probes", 32'(probes), 32'd5);
        quiet(4, saw_done);
        chk("err_no_done", 32'(saw_done), 32'd0);
        chk("err_result_hold", result_o, 32'hDEAD_BEEF);
        chk("err_sticky", 32'(error_o), 32'd1);

        // Next accepted start clears the error; eq case
        run(32'h4000_0000, 0, 0, 0, got_done, cyc, probes, gts, stable_ok);
        chk("eq_error_clr", 32'(error_o), 32'd0);
        chk("eq_result", result_o, 32'h4000_0000);
`ifdef SAR_EARLY_EXIT_EN
        chk("eq_latency", 32'(cyc), 32'd5);
        chk("eq_probes", 32'(probes), 32'd2);
`else
        chk("eq_latency", 32'(cyc), 32'd65);
        chk("eq_probes", 32'(probes), 32'd32);
`endif

        // Abort on the 10th WAIT cycle, with a valid answer in the same cycle
        run(32'h0F0F_0F0F, 0, 0, 10, got_done, cyc, probes, gts, stable_ok);
        chk("abort_ready", 32'(ready_o), 32'd1);
        chk("abort_pvld", 32'(probe_valid_o), 32'd0);
        quiet(4, saw_done);
        chk("abort_no_done", 32'(saw_done), 32'd0);
        chk("abort_result_hold", result_o, 32'h4000_0000);

        // Reset mid-search with the engine parked in WAIT
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("mid_pvld_before", 32'(probe_valid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_pvld", 32'(probe_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        chk("mid_rst_result", result_o, 32'd0);
        chk("mid_rst_probe", probe_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
